// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types for the round-robin stream arbiter.
// ARB searches for the next requester; PKT holds the grant until the locked packet ends.
package rr_stream_arbiter_pkg;

    typedef enum logic {
        ARB = 1'b0,
        PKT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Upstream (per-source) and downstream stream signals of the arbiter, bundled in one interface.
// Handshake: a beat moves on a rising clk edge where valid and ready are both high; valid never
// depends on ready, and once raised, valid and its payload hold until the beat is accepted.
interface rr_stream_arbiter_if #(
    parameter type DATA_TYPE = logic,
    parameter int  SRC_NUM   = 4
);
    localparam int SRC_ID_W = $clog2(SRC_NUM);

    logic     [SRC_NUM-1:0] SrcValid;
    logic     [SRC_NUM-1:0] SrcReady;
    DATA_TYPE [SRC_NUM-1:0] SrcData;
    logic     [SRC_NUM-1:0] SrcLast;
    logic                   DstValid;
    logic                   DstReady;
    DATA_TYPE               DstData;
    logic                   DstLast;
    logic    [SRC_ID_W-1:0] DstSrcId;

    // The arbiter side.
    modport master (
        input  SrcValid, SrcData, SrcLast, DstReady,
        output SrcReady, DstValid, DstData, DstLast, DstSrcId
    );

    // The environment side: sources and the downstream sink.
    modport slave (
        output SrcValid, SrcData, SrcLast, DstReady,
        input  SrcReady, DstValid, DstData, DstLast, DstSrcId
    );

endinterface

// File: rtl/rr_stream_arbiter_onehot_mux.sv
// AND-OR multiplexer steered by a one-hot select; an all-zero select yields zero.
module rr_stream_arbiter_onehot_mux #(
    parameter type DATA_TYPE = logic,
    parameter int  N         = 4
) (
    input  logic     [N-1:0] sel,
    input  DATA_TYPE [N-1:0] din,
    output DATA_TYPE         dout
);
    localparam int W = $bits(DATA_TYPE);

    logic [W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc | (din[i] & {W{sel[i]}});
        end
    end

    assign dout = DATA_TYPE'(acc);

endmodule

// File: rtl/rr_stream_arbiter.sv
// N:1 round-robin stream arbiter with packet locking and a one-entry registered output stage.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter type DATA_TYPE = logic,
    parameter int  SRC_NUM   = 4,
    localparam int SRC_ID_W  = $clog2(SRC_NUM)
) (
    input  logic   clk,
    input  logic   rst_n,
    rr_stream_arbiter_if.master bus,
    output state_e dbg_state
);

    state_e               state_q, state_d;
    logic  [SRC_ID_W-1:0] ptr_q, ptr_d, lock_q, lock_d;
    logic  [SRC_ID_W-1:0] rr_idx, grant_idx;
    logic   [SRC_NUM-1:0] rr_grant, lock_grant, grant;
    logic [2*SRC_NUM-1:0] req_dbl;
    logic                 rr_found, ld_ok, xfer, mux_last;
    DATA_TYPE             mux_data;

    logic                 dst_valid_q, dst_last_q;
    DATA_TYPE             dst_data_q;
    logic  [SRC_ID_W-1:0] dst_id_q;

    // Gating with rst_n keeps every SrcReady low while reset is held.
    assign ld_ok = rst_n & (~dst_valid_q | bus.DstReady);

    // Requests are duplicated and masked below ptr, so the first set bit is the next in rotation.
    always_comb begin
        req_dbl  = {bus.SrcValid, bus.SrcValid} & ({(2*SRC_NUM){1'b1}} << ptr_q);
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < 2*SRC_NUM; i++) begin
            if (!rr_found && req_dbl[i]) begin
                rr_found = 1'b1;
                rr_idx   = SRC_ID_W'(i % SRC_NUM);
            end
        end
        rr_grant = '0;
        if (rr_found) begin
            rr_grant[rr_idx] = 1'b1;
        end
        lock_grant         = '0;
        lock_grant[lock_q] = bus.SrcValid[lock_q];
    end

    assign grant        = (state_q == PKT) ? lock_grant : rr_grant;
    assign grant_idx    = (state_q == PKT) ? lock_q : rr_idx;
    assign bus.SrcReady = grant & {SRC_NUM{ld_ok}};
    assign xfer         = ld_ok & (|(grant & bus.SrcValid));

    rr_stream_arbiter_onehot_mux #(.DATA_TYPE(DATA_TYPE), .N(SRC_NUM)) u_data_mux (
        .sel  (grant),
        .din  (bus.SrcData),
        .dout (mux_data)
    );

    rr_stream_arbiter_onehot_mux #(.DATA_TYPE(logic), .N(SRC_NUM)) u_last_mux (
        .sel  (grant),
        .din  (bus.SrcLast),
        .dout (mux_last)
    );

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            case (state_q)
                ARB: begin
                    if (!mux_last) begin
                        state_d = PKT;
                        lock_d  = grant_idx;
                    end
                end
                PKT: begin
                    if (mux_last) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
            // Only packet ends rotate priority, so a locked packet cannot be split.
            if (mux_last) begin
                ptr_d = (grant_idx == SRC_ID_W'(SRC_NUM - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            lock_q      <= '0;
            ptr_q       <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_last_q  <= 1'b0;
            dst_id_q    <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            if (xfer) begin
                dst_valid_q <= 1'b1;
                dst_data_q  <= mux_data;
                dst_last_q  <= mux_last;
                dst_id_q    <= grant_idx;
            end else if (bus.DstReady) begin
                dst_valid_q <= 1'b0;
            end
        end
    end

    assign bus.DstValid = dst_valid_q;
    assign bus.DstData  = dst_data_q;
    assign bus.DstLast  = dst_last_q;
    assign bus.DstSrcId = dst_id_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scenario bench for rr_stream_arbiter: per-source beat queues drive the inputs, and an
// expected queue of {src_id, last, data} is checked against every downstream transfer.
module tb_rr_stream_arbiter;
    import rr_stream_arbiter_pkg::*;

    localparam int N = 4;
    typedef logic [7:0] data_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;

    always #5 clk = ~clk;

    rr_stream_arbiter_if #(.DATA_TYPE(data_t), .SRC_NUM(N)) bus ();

    rr_stream_arbiter #(.DATA_TYPE(data_t), .SRC_NUM(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [8:0]  src_q [N][$];
    logic [10:0] exp_q [$];
    logic [N-1:0] hold = '0;
    logic         rst_req = 1'b0;
    logic         dst_ready = 1'b1;
    logic [N-1:0] fire;
    logic         dst_fire;
    int           errors = 0;
    int           checks = 0;

    // ---------------- driver tasks ----------------
    task automatic push_beat(input int src, input bit last, input bit expect_out);
        data_t d;
        d = data_t'($urandom_range(0, 255));
        src_q[src].push_back({last, d});
        if (expect_out) begin
            exp_q.push_back({2'(src), last, d});
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
        end
        exp_q.delete();
    endtask

    // One clock: drive at the falling edge, sample just after, account for the coming rising edge.
    task automatic cycle();
        logic [10:0] got;
        logic [10:0] exp;
        @(negedge clk);
        rst_n        = rst_req;
        bus.DstReady = dst_ready;
        for (int i = 0; i < N; i++) begin
            bus.SrcValid[i] = (src_q[i].size() > 0) && !hold[i];
            bus.SrcData[i]  = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
            bus.SrcLast[i]  = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
        end
        #1;
        fire     = bus.SrcValid & bus.SrcReady;
        dst_fire = bus.DstValid & bus.DstReady & rst_n;
        checks++;
        if ($countones(bus.SrcReady) > 1) begin
            errors++;
            $display("FAIL ready_onehot: SrcReady=%b, required at most one bit set", bus.SrcReady);
        end
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                void'(src_q[i].pop_front());
            end
        end
        if (dst_fire) begin
            checks++;
            got = {bus.DstSrcId, bus.DstLast, bus.DstData};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got id=%0d last=%0b data=%h, required no beat",
                         got[10:9], got[8], got[7:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL beat: got id=%0d last=%0b data=%h, required id=%0d last=%0b data=%h",
                             got[10:9], got[8], got[7:0], exp[10:9], exp[8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b0;
        cycle();
        checks++;
        if (bus.SrcReady !== '0) begin
            errors++;
            $display("FAIL reset_ready: SrcReady=%b, required 0000", bus.SrcReady);
        end
        cycle();
        checks++;
        if (bus.DstValid !== 1'b0 || bus.SrcReady !== '0 || dbg_state !== ARB) begin
            errors++;
            $display("FAIL reset_state: DstValid=%b SrcReady=%b state=%0d, required 0 0000 ARB",
                     bus.DstValid, bus.SrcReady, dbg_state);
        end
        rst_req = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        flush();
        hold      = '0;
        dst_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_beat(i, 1'b1, 1'b1);
        end
        do_reset();
        cycle();
        checks++;
        if (bus.SrcReady !== 4'b0001) begin
            errors++;
            $display("FAIL first_grant: SrcReady=%b, required 0001", bus.SrcReady);
        end
        cycle();
        checks++;
        if (bus.DstValid !== 1'b1 || bus.DstSrcId !== 2'd0) begin
            errors++;
            $display("FAIL first_beat: DstValid=%b DstSrcId=%0d, required 1 0", bus.DstValid, bus.DstSrcId);
        end
        drain("reset");
    endtask

    task automatic test_round_robin();
        do_reset();
        push_beat(0, 1'b1, 1'b1);
        push_beat(1, 1'b1, 1'b1);
        push_beat(2, 1'b1, 1'b1);
        push_beat(3, 1'b1, 1'b1);
        push_beat(0, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k <= 5) begin
                checks++;
                if ($countones(fire) != 1) begin
                    errors++;
                    $display("FAIL rr_onehot cycle %0d: fire=%b, required exactly one", k, fire);
                end
            end
            if (k >= 2) begin
                checks++;
                if (!dst_fire) begin
                    errors++;
                    $display("FAIL rr_throughput cycle %0d: dst_fire=0, required 1", k);
                end
            end
        end
        drain("round_robin");
    endtask

    task automatic test_packet_lock();
        do_reset();
        push_beat(2, 1'b0, 1'b1);
        push_beat(2, 1'b0, 1'b1);
        push_beat(2, 1'b1, 1'b1);
        push_beat(0, 1'b1, 1'b1);
        push_beat(1, 1'b1, 1'b1);
        hold = 4'b0011;
        cycle();
        hold = '0;
        cycle();
        checks++;
        if (dbg_state !== PKT) begin
            errors++;
            $display("FAIL lock_state: state=%0d, required PKT", dbg_state);
        end
        drain("packet_lock");
    endtask

    task automatic test_backpressure();
        logic [10:0] held;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_beat(i, 1'b1, 1'b1);
            end
        end
        repeat (3) cycle();
        dst_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k == 0) begin
                held = {bus.DstSrcId, bus.DstLast, bus.DstData};
            end else begin
                checks++;
                if ({bus.DstSrcId, bus.DstLast, bus.DstData} !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h, required %h", {bus.DstSrcId, bus.DstLast, bus.DstData}, held);
                end
            end
            checks++;
            if (bus.DstValid !== 1'b1 || bus.SrcReady !== '0) begin
                errors++;
                $display("FAIL stall_ready: DstValid=%b SrcReady=%b, required 1 0000", bus.DstValid, bus.SrcReady);
            end
        end
        dst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (!dst_fire) begin
                errors++;
                $display("FAIL resume_throughput cycle %0d: dst_fire=0, required 1", k);
            end
        end
        drain("backpressure");
    endtask

    task automatic test_lock_gap();
        do_reset();
        push_beat(1, 1'b0, 1'b1);
        push_beat(1, 1'b1, 1'b1);
        push_beat(3, 1'b1, 1'b1);
        hold = 4'b1000;
        cycle();
        hold = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.SrcReady !== '0) begin
                errors++;
                $display("FAIL gap_blocked cycle %0d: SrcReady=%b, required 0000", k, bus.SrcReady);
            end
        end
        hold = '0;
        drain("lock_gap");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_beat(2, 1'b1, 1'b1);
        hold = 4'b1011;
        cycle();
        push_beat(1, 1'b0, 1'b0);
        push_beat(1, 1'b1, 1'b0);
        push_beat(0, 1'b1, 1'b0);
        hold = 4'b1101;
        cycle();
        hold      = 4'b1111;
        dst_ready = 1'b0;
        cycle();
        checks++;
        if (dbg_state !== PKT || bus.DstValid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lock: state=%0d DstValid=%b, required PKT 1", dbg_state, bus.DstValid);
        end
        do_reset();
        flush();
        hold      = '0;
        dst_ready = 1'b1;
        push_beat(0, 1'b1, 1'b1);
        push_beat(1, 1'b1, 1'b1);
        push_beat(3, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus.SrcReady !== 4'b0001 || bus.DstValid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: SrcReady=%b DstValid=%b, required 0001 0", bus.SrcReady, bus.DstValid);
        end
        drain("reset_mid_packet");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.SrcValid = '0;
        bus.SrcData  = '0;
        bus.SrcLast  = '0;
        bus.DstReady = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_lock_gap();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin N:1 stream arbiter with packet locking. It shares one downstream valid/ready channel between SRC_NUM upstream sources.
- Produces a one-hot grant, which drives a one-hot data mux to steer the data.
- Output stage is registered (one-entry buffer), so downstream timing is isolated from the arbitration logic.
- Sits in front of any shared sink: bus master port, shared FIFO, or shared compute unit.

Parameters:
- DATA_TYPE, logic, payload type carried per beat.
- SRC_NUM, 4, number of upstream sources (>=2).
- SRC_ID_W, $clog2(SRC_NUM), width of the source-index output (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SrcValid  input  [SRC_NUM-1:0]  per-source beat valid.
- SrcReady  output  [SRC_NUM-1:0]  per-source beat accept; at most one bit set.
- SrcData  input  DATA_TYPE [SRC_NUM-1:0]  per-source payload.
- SrcLast  input  [SRC_NUM-1:0]  per-source end-of-packet marker.
- DstValid  output  1  output beat valid (registered).
- DstReady  input  1  downstream accept.
- DstData  output  DATA_TYPE  output payload (registered).
- DstLast  output  1  end-of-packet (registered).
- DstSrcId  output  SRC_ID_W  index of the source that produced the current output beat (registered).

Behaviour:
- Reset: synchronous on clk when rst_n=0.
  - Reset values: DstValid=0, DstData='0, DstLast=0, DstSrcId=0, lock=0, priority pointer=0.
  - SrcReady=0 during reset.
  - Reset mid-packet drops the lock and any buffered beat; no beat is emitted after reset.
- Handshake: a beat transfers when Valid&Ready are both high on a clock edge.
  - Valid must not depend on Ready, on both sides.
  - The output beat and its fields are held stable while DstValid=1 and DstReady=0.
- Output register can load when: ld_ok = ~DstValid | DstReady.
- Grant (one-hot, combinational):
  - Unlocked (ARB): first index i with SrcValid[i]=1, searching ptr, ptr+1, ..., wrapping modulo SRC_NUM. Grant is zero if no source is valid.
  - Locked (PKT): grant = locked source only, regardless of other requests.
- SrcReady = grant & {SRC_NUM{ld_ok}}.
- On a source transfer:
  - DstData/DstLast load from the one-hot mux of SrcData/SrcLast by grant; DstSrcId = index; DstValid=1.
- When DstReady=1 and no source transfers, DstValid clears to 0.
- Latency: 1 cycle from source acceptance to DstValid.
- Throughput: 1 beat/cycle when DstReady is held high.
- FSM, 2 states:
  - ARB -> PKT on a transfer with SrcLast=0; the lock index is captured.
  - PKT -> ARB on a transfer with SrcLast=1 from the locked source.
  - ARB stays ARB on a transfer with SrcLast=1 (single-beat packet).
- Priority pointer update: on every transfer with SrcLast=1, ptr <= (granted index + 1) mod SRC_NUM. This is wrap-around, not a saturating count.
- Pointer is not updated on non-last beats or idle cycles.
- Locked source deasserts SrcValid mid-packet: the lock holds and other sources stay blocked (no interleaving).
- Simultaneous requests: exactly one grant. Fairness: every requester is served within SRC_NUM-1 packets of other sources.
- Downstream stall with a full register: SrcReady all 0; grant and lock are unchanged.

Decomposition:
- Shared package (stream_arb_pkg): state enum {ARB, PKT}.
- Sub-module: the team's existing one-hot mux (OnehotMux), instantiated twice.
  - Once for DATA_TYPE data.
  - Once for Last, with DATA_TYPE=logic.
- Round-robin search: inline, using a double-width masked priority encode.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles with all SrcValid=1 -> DstValid=0, SrcReady=0. After release: first grant goes to src0, DstSrcId=0 one cycle later.
2. All 4 sources valid, all single-beat (SrcLast=1), DstReady=1 -> DstSrcId sequence 0,1,2,3,0 on consecutive cycles; SrcReady one-hot every cycle.
3. Packet lock: src2 sends a 3-beat packet (Last on beat 3) while src0/src1 are valid -> DstSrcId=2,2,2, then 3? No: src3 is not valid, so the next grant is 0, then 1. No interleave occurs.
4. Backpressure: DstReady=0 for 5 cycles with DstValid=1 -> DstData/DstLast/DstSrcId are stable and SrcReady=0. DstReady=1 -> the held beat transfers, then streaming resumes at 1 beat/cycle.
5. Locked source gap: src1 packet beat 1 (Last=0), then SrcValid[1]=0 for 3 cycles with src3 valid -> no src3 beat is emitted until src1's Last beat transfers.
6. Reset mid-packet: assert rst_n=0 during PKT, src1 locked -> after release, ptr=0, lock cleared, DstValid=0; src0 requesting is granted first.
